// File: rtl/stream_demux_1to2.sv
// Buffered 1-to-2 stream demultiplexer: each output owns a DEPTH-entry FIFO so one stalled
// consumer never blocks the other. Optional per-output accept counters with STREAM_DEMUX_COUNT_EN.
module stream_demux_1to2 #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] IN,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic             SEL,
    output logic [WIDTH-1:0] OUT_0,
    output logic             OUT_0_VALID,
    input  logic             OUT_0_READY,
    output logic [WIDTH-1:0] OUT_1,
    output logic             OUT_1_VALID,
    input  logic             OUT_1_READY
`ifdef STREAM_DEMUX_COUNT_EN
    ,
    output logic [31:0]      CNT_0,
    output logic [31:0]      CNT_1
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    logic [WIDTH-1:0] mem_q [2][DEPTH];
    ptr_t             wr_q  [2];
    ptr_t             wr_d  [2];
    ptr_t             rd_q  [2];
    ptr_t             rd_d  [2];
    cnt_t             cnt_q [2];
    cnt_t             cnt_d [2];

    logic [1:0] full;
    logic [1:0] nonempty;
    logic [1:0] out_rdy;
    logic [1:0] push;
    logic [1:0] pop;
    logic       accept;

    always_comb begin
        full     = '0;
        nonempty = '0;
        for (int n = 0; n < 2; n++) begin
            full[n]     = (cnt_q[n] == cnt_t'(DEPTH));
            nonempty[n] = (cnt_q[n] != '0);
        end
    end

    // Readiness looks only at registered counts, so a same-cycle pop cannot open a full FIFO.
    assign IN_READY = ~full[SEL];
    assign accept   = IN_VALID & IN_READY;
    assign push     = accept ? (SEL ? 2'b10 : 2'b01) : 2'b00;
    assign out_rdy  = {OUT_1_READY, OUT_0_READY};
    assign pop      = nonempty & out_rdy;

    always_comb begin
        for (int n = 0; n < 2; n++) begin
            wr_d[n]  = wr_q[n];
            rd_d[n]  = rd_q[n];
            cnt_d[n] = cnt_q[n];
            if (push[n]) begin
                wr_d[n] = wr_q[n] + ptr_t'(1);
            end
            if (pop[n]) begin
                rd_d[n] = rd_q[n] + ptr_t'(1);
            end
            case ({push[n], pop[n]})
                2'b10:   cnt_d[n] = cnt_q[n] + cnt_t'(1);
                2'b01:   cnt_d[n] = cnt_q[n] - cnt_t'(1);
                default: cnt_d[n] = cnt_q[n];
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int n = 0; n < 2; n++) begin
                wr_q[n]  <= '0;
                rd_q[n]  <= '0;
                cnt_q[n] <= '0;
            end
        end else begin
            for (int n = 0; n < 2; n++) begin
                wr_q[n]  <= wr_d[n];
                rd_q[n]  <= rd_d[n];
                cnt_q[n] <= cnt_d[n];
            end
        end
    end

    // Storage is not reset; empty outputs are forced to zero instead.
    always_ff @(posedge CLK) begin
        if (accept) begin
            mem_q[SEL][wr_q[SEL]] <= IN;
        end
    end

    assign OUT_0       = nonempty[0] ? mem_q[0][rd_q[0]] : '0;
    assign OUT_1       = nonempty[1] ? mem_q[1][rd_q[1]] : '0;
    assign OUT_0_VALID = nonempty[0];
    assign OUT_1_VALID = nonempty[1];

`ifdef STREAM_DEMUX_COUNT_EN
    logic [31:0] acc_q [2];

    always_ff @(posedge CLK) begin
        if (RST) begin
            acc_q[0] <= '0;
            acc_q[1] <= '0;
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (push[n]) begin
                    acc_q[n] <= acc_q[n] + 32'd1;
                end
            end
        end
    end

    assign CNT_0 = acc_q[0];
    assign CNT_1 = acc_q[1];
`endif

endmodule

// File: tb/tb_stream_demux_1to2.sv
// Directed bench for stream_demux_1to2 (DEPTH=2): cycle table plus streaming and reset-mid-flight sequences.
module tb_stream_demux_1to2;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] IN;
    logic        IN_VALID;
    logic        IN_READY;
    logic        SEL;
    logic [31:0] OUT_0;
    logic        OUT_0_VALID;
    logic        OUT_0_READY;
    logic [31:0] OUT_1;
    logic        OUT_1_VALID;
    logic        OUT_1_READY;
`ifdef STREAM_DEMUX_COUNT_EN
    logic [31:0] CNT_0;
    logic [31:0] CNT_1;
`endif

    stream_demux_1to2 #(.WIDTH(32), .DEPTH(2)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .IN         (IN),
        .IN_VALID   (IN_VALID),
        .IN_READY   (IN_READY),
        .SEL        (SEL),
        .OUT_0      (OUT_0),
        .OUT_0_VALID(OUT_0_VALID),
        .OUT_0_READY(OUT_0_READY),
        .OUT_1      (OUT_1),
        .OUT_1_VALID(OUT_1_VALID),
        .OUT_1_READY(OUT_1_READY)
`ifdef STREAM_DEMUX_COUNT_EN
        ,
        .CNT_0      (CNT_0),
        .CNT_1      (CNT_1)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic        vld;
        logic        sel;
        logic [31:0] din;
        logic        r0;
        logic        r1;
        logic        chk;
        logic        e_rdy;
        logic        e_v0;
        logic [31:0] e_d0;
        logic        e_v1;
        logic [31:0] e_d1;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void add(logic rst, logic vld, logic sel, logic [31:0] din, logic r0, logic r1,
                                logic chk, logic e_rdy, logic e_v0, logic [31:0] e_d0,
                                logic e_v1, logic [31:0] e_d1);
        vec_t v;
        v = '{rst, vld, sel, din, r0, r1, chk, e_rdy, e_v0, e_d0, e_v1, e_d1};
        tbl.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic vld, input logic sel, input logic [31:0] din,
                         input logic r0, input logic r1);
        @(negedge CLK);
        RST         = rst;
        IN_VALID    = vld;
        SEL         = sel;
        IN          = din;
        OUT_0_READY = r0;
        OUT_1_READY = r1;
        #1;
    endtask

    task automatic check_outs(input string tag, input logic e_rdy, input logic e_v0, input logic [31:0] e_d0,
                              input logic e_v1, input logic [31:0] e_d1);
        check({tag, ".in_ready"}, {31'd0, IN_READY}, {31'd0, e_rdy});
        check({tag, ".v0"}, {31'd0, OUT_0_VALID}, {31'd0, e_v0});
        check({tag, ".d0"}, OUT_0, e_d0);
        check({tag, ".v1"}, {31'd0, OUT_1_VALID}, {31'd0, e_v1});
        check({tag, ".d1"}, OUT_1, e_d1);
    endtask

    initial begin
        RST = 1'b1; IN = '0; IN_VALID = 1'b0; SEL = 1'b0; OUT_0_READY = 1'b0; OUT_1_READY = 1'b0;

        //   rst vld sel din           r0 r1 chk rdy v0 d0            v1 d1
        add(1, 0, 0, 32'h0,         0, 0, 0, 1, 0, 32'h0,         0, 32'h0);
        add(1, 0, 0, 32'h0,         0, 0, 1, 1, 0, 32'h0,         0, 32'h0);
        add(0, 0, 0, 32'h0,         0, 0, 1, 1, 0, 32'h0,         0, 32'h0);
        add(0, 1, 1, 32'hDEADBEEF,  0, 0, 1, 1, 0, 32'h0,         0, 32'h0);
        add(0, 0, 0, 32'h0,         0, 0, 1, 1, 0, 32'h0,         1, 32'hDEADBEEF);
        add(0, 0, 0, 32'h0,         0, 1, 1, 1, 0, 32'h0,         1, 32'hDEADBEEF);
        add(0, 0, 0, 32'h0,         0, 0, 1, 1, 0, 32'h0,         0, 32'h0);
        add(0, 1, 0, 32'h1,         0, 0, 1, 1, 0, 32'h0,         0, 32'h0);
        add(0, 1, 0, 32'h2,         0, 0, 1, 1, 1, 32'h1,         0, 32'h0);
        add(0, 1, 0, 32'h3,         0, 0, 1, 0, 1, 32'h1,         0, 32'h0);
        add(0, 1, 0, 32'h3,         1, 0, 1, 0, 1, 32'h1,         0, 32'h0);
        add(0, 1, 0, 32'h3,         1, 0, 1, 1, 1, 32'h2,         0, 32'h0);
        add(0, 0, 0, 32'h0,         1, 0, 1, 1, 1, 32'h3,         0, 32'h0);
        add(0, 0, 0, 32'h0,         0, 0, 1, 1, 0, 32'h0,         0, 32'h0);
        add(0, 1, 0, 32'hB0,        0, 0, 1, 1, 0, 32'h0,         0, 32'h0);
        add(0, 1, 0, 32'hB1,        0, 0, 1, 1, 1, 32'hB0,        0, 32'h0);
        add(0, 1, 1, 32'hA5A5A5A5,  0, 0, 1, 1, 1, 32'hB0,        0, 32'h0);
        add(0, 1, 0, 32'hB2,        0, 0, 1, 0, 1, 32'hB0,        1, 32'hA5A5A5A5);
        add(0, 0, 0, 32'h0,         1, 1, 1, 0, 1, 32'hB0,        1, 32'hA5A5A5A5);
        add(0, 0, 0, 32'h0,         1, 0, 1, 1, 1, 32'hB1,        0, 32'h0);
        add(0, 0, 0, 32'h0,         1, 1, 1, 1, 0, 32'h0,         0, 32'h0);
        add(0, 0, 0, 32'h0,         0, 0, 1, 1, 0, 32'h0,         0, 32'h0);

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].vld, tbl[i].sel, tbl[i].din, tbl[i].r0, tbl[i].r1);
            if (tbl[i].chk) begin
                check_outs($sformatf("vec%0d", i), tbl[i].e_rdy, tbl[i].e_v0, tbl[i].e_d0,
                           tbl[i].e_v1, tbl[i].e_d1);
            end
`ifdef STREAM_DEMUX_COUNT_EN
            if (i == 2) begin
                check("cnt0_after_reset", CNT_0, 32'd0);
                check("cnt1_after_reset", CNT_1, 32'd0);
            end
`endif
        end

        // Streaming 0..9 alternating SEL with both consumers ready; pointers wrap several times.
        for (int i = 0; i <= 10; i++) begin
            logic [31:0] prev;
            prev = 32'(i - 1);
            if (i < 10) drive(0, 1, i[0], 32'(i), 1, 1);
            else        drive(0, 0, 0, 32'h0, 1, 1);
            if (i < 10) check($sformatf("stream%0d.in_ready", i), {31'd0, IN_READY}, 32'd1);
            if (i == 0) begin
                check("stream0.v0", {31'd0, OUT_0_VALID}, 32'd0);
                check("stream0.v1", {31'd0, OUT_1_VALID}, 32'd0);
            end else if (prev[0] == 1'b0) begin
                check($sformatf("stream%0d.v0", i), {31'd0, OUT_0_VALID}, 32'd1);
                check($sformatf("stream%0d.d0", i), OUT_0, prev);
                check($sformatf("stream%0d.v1", i), {31'd0, OUT_1_VALID}, 32'd0);
            end else begin
                check($sformatf("stream%0d.v1", i), {31'd0, OUT_1_VALID}, 32'd1);
                check($sformatf("stream%0d.d1", i), OUT_1, prev);
                check($sformatf("stream%0d.v0", i), {31'd0, OUT_0_VALID}, 32'd0);
            end
        end
`ifdef STREAM_DEMUX_COUNT_EN
        check("cnt0_after_stream", CNT_0, 32'd10);
        check("cnt1_after_stream", CNT_1, 32'd7);
`endif

        // Reset mid-flight with both FIFOs holding two words.
        drive(0, 1, 0, 32'hC0, 0, 0);
        drive(0, 1, 0, 32'hC1, 0, 0);
        drive(0, 1, 1, 32'hD0, 0, 0);
        drive(0, 1, 1, 32'hD1, 0, 0);
        drive(0, 0, 0, 32'h0, 0, 0);
        check_outs("full_both", 1'b0, 1'b1, 32'hC0, 1'b1, 32'hD0);
        drive(1, 1, 1, 32'hEE, 1, 1);
        drive(0, 0, 0, 32'h0, 0, 0);
        check_outs("post_rst", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
`ifdef STREAM_DEMUX_COUNT_EN
        check("cnt0_post_rst", CNT_0, 32'd0);
        check("cnt1_post_rst", CNT_1, 32'd0);
`endif
        drive(0, 1, 0, 32'hE0, 0, 0);
        drive(0, 0, 0, 32'h0, 0, 0);
        check_outs("after_rst_push", 1'b1, 1'b1, 32'hE0, 1'b0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
